// File: rtl/c_x_pkg.sv
// c_x_pkg: shared types and constants for the C_X series-evaluation controller.
package c_x_pkg;

    // Controller states; all eight 3-bit encodings are in use.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_REL = 3'd1,
        LOAD     = 3'd2,
        SQUARE   = 3'd3,
        ROM_WAIT = 3'd4,
        MUL_X    = 3'd5,
        MUL_C    = 3'd6,
        DONE     = 3'd7
    } c_x_state_t;

    // bus1 feeds the x register: external operand or multiplier product.
    localparam logic BUS1_EXT  = 1'b1;
    localparam logic BUS1_PROD = 1'b0;

    // bus2 is multiplier operand A: x register or coefficient ROM.
    localparam logic BUS2_XREG = 1'b1;
    localparam logic BUS2_COEF = 1'b0;

    // bus3 is multiplier operand B: x register or term register.
    localparam logic BUS3_XREG = 1'b1;
    localparam logic BUS3_TREG = 1'b0;

    // Accumulator operation.
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/c_x_controller_if.sv
// c_x_controller_if: host handshake plus datapath control/status lines.
//
// Handshake: the host raises start (a level) while ready is high.
// The controller leaves IDLE, then waits for start to return to 0 before it
// loads operands. This means one start assertion produces exactly one run.
// start is ignored while the run is in progress. done pulses for one cycle
// when the result register holds the final value. ready is high only in IDLE.
interface c_x_controller_if;
    import c_x_pkg::*;

    // Host side
    logic start;
    logic ready;
    logic done;

    // Datapath status
    logic lt_comp;
    logic cnt_co;
    logic sub_flag;

    // Datapath controls
    logic x_ld;
    logic y_ld;
    logic r_ld;
    logic r_init;
    logic t_ld;
    logic t_init;
    logic cnt_en;
    logic cnt_init;
    logic add_sub_crl;
    logic bus1_sel;
    logic bus2_sel;
    logic bus3_sel;

    // Controller side
    modport master (
        input  start, lt_comp, cnt_co, sub_flag,
        output ready, done, x_ld, y_ld, r_ld, r_init, t_ld, t_init,
               cnt_en, cnt_init, add_sub_crl, bus1_sel, bus2_sel, bus3_sel
    );

    // Host/datapath side
    modport slave (
        output start, lt_comp, cnt_co, sub_flag,
        input  ready, done, x_ld, y_ld, r_ld, r_init, t_ld, t_init,
               cnt_en, cnt_init, add_sub_crl, bus1_sel, bus2_sel, bus3_sel
    );

endinterface

// File: rtl/c_x_wait_timer.sv
// c_x_wait_timer: 2-bit down-counter that spaces ROM accesses.
// Loading sets the count to ROM_LAT-1. zero_o then rises after ROM_LAT-1
// enabled cycles, so a state that leaves on zero_o lasts exactly ROM_LAT cycles.
module c_x_wait_timer
    import c_x_pkg::*;
#(
    parameter int unsigned ROM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam logic [1:0] LOAD_VAL = 2'(ROM_LAT - 1);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: reload has priority, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 2'd0);

endmodule

// File: rtl/c_x_controller.sv
// c_x_controller: Moore FSM sequencing the C_X series-evaluation datapath.
// Optional build macro C_X_EARLY_TERM_EN: when defined, lt_comp high in MUL_C
// ends the series after that term has been accumulated. When undefined,
// all 16 terms always run.
module c_x_controller
    import c_x_pkg::*;
#(
    parameter bit          SQUARE_X = 1'b1,
    parameter int unsigned ROM_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    c_x_controller_if.master bus,
    output c_x_state_t       dbg_state_o
);

    c_x_state_t state_q;
    c_x_state_t state_d;
    logic       wait_zero;
    logic       term_stop;

    // The timer reloads in every state other than ROM_WAIT.
    // This means every entry into ROM_WAIT starts from a full count.
    c_x_wait_timer #(
        .ROM_LAT (ROM_LAT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q != ROM_WAIT),
        .en_i   (state_q == ROM_WAIT),
        .zero_o (wait_zero)
    );

`ifdef C_X_EARLY_TERM_EN
    assign term_stop = bus.cnt_co | bus.lt_comp;
`else
    logic unused_lt_comp;
    assign unused_lt_comp = bus.lt_comp;
    assign term_stop      = bus.cnt_co;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:     state_d = bus.start ? WAIT_REL : IDLE;
            WAIT_REL: state_d = bus.start ? WAIT_REL : LOAD;
            LOAD:     state_d = SQUARE_X ? SQUARE : ROM_WAIT;
            SQUARE:   state_d = ROM_WAIT;
            ROM_WAIT: state_d = wait_zero ? MUL_X : ROM_WAIT;
            MUL_X:    state_d = MUL_C;
            MUL_C:    state_d = term_stop ? DONE : ROM_WAIT;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode from the current state (add_sub_crl follows sub_flag in MUL_C).
    always_comb begin
        bus.ready       = 1'b0;
        bus.done        = 1'b0;
        bus.x_ld        = 1'b0;
        bus.y_ld        = 1'b0;
        bus.r_ld        = 1'b0;
        bus.r_init      = 1'b0;
        bus.t_ld        = 1'b0;
        bus.t_init      = 1'b0;
        bus.cnt_en      = 1'b0;
        bus.cnt_init    = 1'b0;
        bus.add_sub_crl = ADD;
        bus.bus1_sel    = BUS1_PROD;
        bus.bus2_sel    = BUS2_COEF;
        bus.bus3_sel    = BUS3_TREG;
        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
            end
            LOAD: begin
                bus.bus1_sel = BUS1_EXT;
                bus.x_ld     = 1'b1;
                bus.y_ld     = 1'b1;
                bus.r_init   = 1'b1;
                bus.t_init   = 1'b1;
                bus.cnt_init = 1'b1;
            end
            SQUARE: begin
                bus.bus1_sel = BUS1_PROD;
                bus.bus2_sel = BUS2_XREG;
                bus.bus3_sel = BUS3_XREG;
                bus.x_ld     = 1'b1;
            end
            MUL_X: begin
                bus.bus2_sel = BUS2_XREG;
                bus.bus3_sel = BUS3_TREG;
                bus.t_ld     = 1'b1;
            end
            MUL_C: begin
                bus.bus2_sel    = BUS2_COEF;
                bus.bus3_sel    = BUS3_TREG;
                bus.t_ld        = 1'b1;
                bus.r_ld        = 1'b1;
                bus.add_sub_crl = bus.sub_flag ? SUB : ADD;
                bus.cnt_en      = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_c_x_controller.sv
module tb_c_x_controller;
  import c_x_pkg::*;

  // Expected run record: {x_ld pulses, r_ld pulses, cycles from LOAD to DONE}
  localparam int W = 24;
  // Default DUT: LOAD + SQUARE + 16*(1+2) = 50; second DUT: LOAD + 16*(3+2) = 81
  localparam int LAT_A = 50;
  localparam int LAT_B = 81;
`ifdef C_X_EARLY_TERM_EN
  localparam int EARLY_TERMS = 4;
`else
  localparam int EARLY_TERMS = 16;
`endif

  logic clk;
  logic rst;
  logic [1:0] start_v;
  logic early_lt;
  logic [4:0] cnt_a;
  logic [4:0] cnt_b;
  c_x_state_t dbg_a;
  c_x_state_t dbg_b;

  c_x_controller_if bus_a ();
  c_x_controller_if bus_b ();

  c_x_controller #(.SQUARE_X(1'b1), .ROM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state_o(dbg_a)
  );
  c_x_controller #(.SQUARE_X(1'b0), .ROM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state_o(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- datapath model ----------------
  initial begin
    cnt_a = '0;
    cnt_b = '0;
  end
  always @(posedge clk) begin
    if (bus_a.cnt_init) cnt_a <= '0;
    else if (bus_a.cnt_en) cnt_a <= cnt_a + 5'd1;
    if (bus_b.cnt_init) cnt_b <= '0;
    else if (bus_b.cnt_en) cnt_b <= cnt_b + 5'd1;
  end

  assign bus_a.start    = start_v[0];
  assign bus_b.start    = start_v[1];
  assign bus_a.cnt_co   = (cnt_a == 5'd15);
  assign bus_b.cnt_co   = (cnt_b == 5'd15);
  assign bus_a.sub_flag = cnt_a[1];
  assign bus_b.sub_flag = cnt_b[1];
  assign bus_a.lt_comp  = early_lt && (cnt_a == 5'd3);
  assign bus_b.lt_comp  = 1'b0;

  // ---------------- observation vectors ----------------
  logic [1:0] m_x_ld, m_r_ld, m_ready, m_done, m_add_sub, m_sub, m_any, m_load, m_mulx;
  assign m_x_ld    = {bus_b.x_ld, bus_a.x_ld};
  assign m_r_ld    = {bus_b.r_ld, bus_a.r_ld};
  assign m_ready   = {bus_b.ready, bus_a.ready};
  assign m_done    = {bus_b.done, bus_a.done};
  assign m_add_sub = {bus_b.add_sub_crl, bus_a.add_sub_crl};
  assign m_sub     = {bus_b.sub_flag, bus_a.sub_flag};
  assign m_any[0]  = bus_a.x_ld | bus_a.y_ld | bus_a.r_ld | bus_a.r_init | bus_a.t_ld |
                     bus_a.t_init | bus_a.cnt_en | bus_a.cnt_init | bus_a.add_sub_crl |
                     bus_a.bus1_sel | bus_a.bus2_sel | bus_a.bus3_sel;
  assign m_any[1]  = bus_b.x_ld | bus_b.y_ld | bus_b.r_ld | bus_b.r_init | bus_b.t_ld |
                     bus_b.t_init | bus_b.cnt_en | bus_b.cnt_init | bus_b.add_sub_crl |
                     bus_b.bus1_sel | bus_b.bus2_sel | bus_b.bus3_sel;
  assign m_load    = {bus_b.x_ld & bus_b.y_ld & bus_b.bus1_sel,
                      bus_a.x_ld & bus_a.y_ld & bus_a.bus1_sel};
  assign m_mulx    = {bus_b.t_ld & bus_b.bus2_sel & ~bus_b.r_ld,
                      bus_a.t_ld & bus_a.bus2_sel & ~bus_a.r_ld};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int lat[2], rld[2], xld[2], idle_run[2], load_cnt[2], done_cnt[2];
  bit run[2], prev_done[2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; rld[i] = 0; xld[i] = 0; idle_run[i] = 0;
      load_cnt[i] = 0; done_cnt[i] = 0; run[i] = 0; prev_done[i] = 0;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        if (m_r_ld[d] || m_add_sub[d])
          chk("add_sub", 32'(m_add_sub[d]), 32'(m_r_ld[d] ? m_sub[d] : 1'b0));
        if (m_mulx[d])
          chk("rom_wait_cycles", 32'(idle_run[d]), (d == 0) ? 32'd1 : 32'd3);
        if (prev_done[d])
          chk("ready_after_done", 32'(m_ready[d]), 32'd1);
        prev_done[d] <= m_done[d];
        if (!m_any[d] && !m_ready[d] && !m_done[d]) idle_run[d] <= idle_run[d] + 1;
        else idle_run[d] <= 0;

        if (m_load[d]) begin
          run[d] <= 1'b1;
          lat[d] <= 0;
          rld[d] <= 0;
          xld[d] <= 1;
          load_cnt[d] <= load_cnt[d] + 1;
        end else if (run[d]) begin
          lat[d] <= lat[d] + 1;
          if (m_x_ld[d]) xld[d] <= xld[d] + 1;
          if (m_r_ld[d]) rld[d] <= rld[d] + 1;
        end

        if (m_done[d]) begin
          done_cnt[d] <= done_cnt[d] + 1;
          run[d] <= 1'b0;
          got_v = {8'(xld[d]), 8'(rld[d]), 8'(lat[d] + 1)};
          if (d == 0 && exp_q0.size() > 0) begin
            exp_v = exp_q0.pop_front();
            chk("run_a_result", 32'(got_v), 32'(exp_v));
          end else if (d == 1 && exp_q1.size() > 0) begin
            exp_v = exp_q1.pop_front();
            chk("run_b_result", 32'(got_v), 32'(exp_v));
          end else begin
            chk("unexpected_done", 32'd1, 32'd0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int d, input int xl, input int rl, input int lt);
    if (d == 0) exp_q0.push_back({8'(xl), 8'(rl), 8'(lt)});
    else exp_q1.push_back({8'(xl), 8'(rl), 8'(lt)});
  endtask

  task automatic start_run(input int d, input int hold);
    int guard = 0;
    while (!m_ready[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_before_start", 32'(m_ready[d]), 32'd1);
    start_v[d] = 1'b1;
    repeat (hold) @(negedge clk);
    chk("no_load_while_held", 32'(m_load[d]), 32'd0);
    start_v[d] = 1'b0;
    @(negedge clk);
    chk("load_after_release", 32'(m_load[d]), 32'd1);
  endtask

  // mode 0: start low, 1: start held high, 2: start pulsed in every MUL_C
  task automatic wait_done(input int d, input int mode, input int max_cyc);
    int n0 = done_cnt[d];
    int k = 0;
    if (mode == 1) start_v[d] = 1'b1;
    while (done_cnt[d] == n0 && k < max_cyc) begin
      if (mode == 2) start_v[d] = m_r_ld[d];
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 32'(k < max_cyc), 32'd1);
    if (mode != 1) start_v[d] = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int l1;
    int k;
    rst = 1'b1;
    start_v = 2'b00;
    early_lt = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(m_ready[d]), 32'd1);
      chk("reset_ctl", 32'(m_any[d]), 32'd0);
      chk("reset_done", 32'(m_done[d]), 32'd0);
    end
    chk("reset_state_a", 32'(dbg_a), 32'(IDLE));
    chk("reset_state_b", 32'(dbg_b), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Default run, all 16 terms, alternating sign pairs
    push_exp(0, 2, 16, LAT_A);
    start_run(0, 4);
    wait_done(0, 0, 300);

    // No squaring, 3-cycle ROM
    push_exp(1, 1, 16, LAT_B);
    start_run(1, 4);
    wait_done(1, 0, 300);

    // lt_comp raised on the 4th MUL_C
    early_lt = 1'b1;
    push_exp(0, 2, EARLY_TERMS, 2 + 3 * EARLY_TERMS);
    start_run(0, 2);
    wait_done(0, 0, 300);
    early_lt = 1'b0;

    // Synchronous reset during the 3rd MUL_X
    start_run(0, 3);
    k = 0;
    for (int i = 0; i < 100 && k < 3; i++) begin
      if (m_mulx[0]) k++;
      if (k < 3) @(negedge clk);
    end
    chk("reached_mulx3", 32'(k), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_ready", 32'(m_ready[0]), 32'd1);
    chk("midrun_rst_ctl", 32'(m_any[0]), 32'd0);
    chk("midrun_rst_done", 32'(m_done[0]), 32'd0);
    chk("midrun_rst_state", 32'(dbg_a), 32'(IDLE));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // start pulses in MUL_C are ignored
    push_exp(0, 2, 16, LAT_A);
    l1 = load_cnt[0];
    start_run(0, 1);
    wait_done(0, 2, 300);
    repeat (8) @(negedge clk);
    chk("no_restart_pulses", 32'(load_cnt[0] - l1), 32'd1);

    // start held high through the whole run stalls in WAIT_REL afterwards
    push_exp(0, 2, 16, LAT_A);
    start_run(0, 2);
    wait_done(0, 1, 300);
    l1 = load_cnt[0];
    repeat (10) @(negedge clk);
    chk("held_no_second_load", 32'(load_cnt[0] - l1), 32'd0);
    chk("held_state", 32'(dbg_a), 32'(WAIT_REL));
    chk("held_ready", 32'(m_ready[0]), 32'd0);
    push_exp(0, 2, 16, LAT_A);
    start_v[0] = 1'b0;
    @(negedge clk);
    chk("load_after_held_release", 32'(m_load[0]), 32'd1);
    wait_done(0, 0, 300);

    repeat (3) @(negedge clk);
    chk("queue_a_drained", 32'(exp_q0.size()), 32'd0);
    chk("queue_b_drained", 32'(exp_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
